csr_timer: RTL and testbench

CSR-mapped programmable timer that originates interrupt requests for the n_clic interrupt controller. Software configures it through the core's CSR bus, using the same decoder-driven enable/address/op signals as the other CSR peripherals. It counts prescaled clock ticks against a compare value and raises a one-cycle `interrupt_out` pulse on each match. The block is the interrupt initiator that n_clic responds to; its `interrupt_out` connects to one n_clic interrupt input.

---
 rtl/csr_timer_pkg.sv | 32 +++
 rtl/csr_rmw.sv | 48 ++++
 rtl/csr_timer.sv | 138 +++++++++++++
 tb/tb_csr_timer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - shared CSR types, timer addresses and control-register layout
package csr_timer_pkg;

  typedef logic [11:0] CsrAddrT;
  typedef logic [4:0]  r;
  typedef logic [31:0] word;

  // Encoded as the RISC-V funct3 of the Zicsr instructions; bit 2 marks the immediate forms.
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  localparam CsrAddrT TimerCtrlAddr    = 12'h400;
  localparam CsrAddrT TimerCounterAddr = 12'h401;
  localparam CsrAddrT TimerCompareAddr = 12'h402;

  localparam int CtrlEnBit       = 0;
  localparam int CtrlPeriodicBit = 1;
  localparam int CtrlPendingBit  = 2;
  localparam int CtrlPrescaleLsb = 8;
  localparam int CtrlPrescaleMsb = 15;

  function automatic logic op_is_imm(csr_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// rtl/csr_rmw.sv - combinational CSR read-modify-write: new value and write strobe
//
// Ports:
//   old_value_i  current value of the addressed register
//   csr_op_i     RW/RS/RC and their immediate forms
//   rs1_zimm_i   rs1 index, or the 5-bit zimm for immediate forms
//   rs1_data_i   rs1 register value
//   new_value_o  value to commit
//   write_o      commit strobe (low for set/clear with source index 0)
module csr_rmw
  import csr_timer_pkg::*;
(
  input  word     old_value_i,
  input  csr_op_t csr_op_i,
  input  r        rs1_zimm_i,
  input  word     rs1_data_i,
  output word     new_value_o,
  output logic    write_o
);

  word src;

  always_comb begin
    src         = op_is_imm(csr_op_i) ? {27'd0, rs1_zimm_i} : rs1_data_i;
    new_value_o = old_value_i;
    write_o     = 1'b0;
    case (csr_op_i)
      CSR_RW, CSR_RWI: begin
        new_value_o = src;
        write_o     = 1'b1;
      end
      // Set/clear from x0 (or zimm 0) is a pure read and must not write.
      CSR_RS, CSR_RSI: begin
        new_value_o = old_value_i | src;
        write_o     = (rs1_zimm_i != '0);
      end
      CSR_RC, CSR_RCI: begin
        new_value_o = old_value_i & ~src;
        write_o     = (rs1_zimm_i != '0);
      end
      default: begin
        new_value_o = old_value_i;
        write_o     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - CSR-mapped prescaled compare timer raising one-cycle interrupt pulses
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   csr_enable     decoder has a CSR instruction this cycle
//   csr_addr       CSR address
//   rs1_zimm       rs1 index or zimm
//   rs1_data       rs1 value
//   csr_op         CSR operation
//   csr_out        pre-write value of the addressed register, 0 if not ours
//   interrupt_out  registered one-cycle pulse per compare match
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter CsrAddrT CtrlAddr     = TimerCtrlAddr,
  parameter CsrAddrT CounterAddr  = TimerCounterAddr,
  parameter CsrAddrT CompareAddr  = TimerCompareAddr,
  parameter int      CounterWidth = 32
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    csr_enable,
  input  CsrAddrT csr_addr,
  input  r        rs1_zimm,
  input  word     rs1_data,
  input  csr_op_t csr_op,
  output word     csr_out,
  output logic    interrupt_out
);

  logic                    en_q, en_d;
  logic                    periodic_q, periodic_d;
  logic                    pending_q, pending_d;
  logic [7:0]              prescale_q, prescale_d;
  logic [7:0]              pre_q, pre_d;
  logic [CounterWidth-1:0] counter_q, counter_d;
  logic [CounterWidth-1:0] compare_q, compare_d;
  logic                    irq_q, irq_d;

  logic sel_ctrl, sel_counter, sel_compare;
  logic wr_ctrl, wr_counter, wr_compare;
  logic rmw_we;
  logic tick, match;
  word  ctrl_word, counter_word, compare_word, wdata;

  always_comb begin
    sel_ctrl    = csr_enable && (csr_addr == CtrlAddr);
    sel_counter = csr_enable && (csr_addr == CounterAddr);
    sel_compare = csr_enable && (csr_addr == CompareAddr);

    ctrl_word                                  = '0;
    ctrl_word[CtrlEnBit]                       = en_q;
    ctrl_word[CtrlPeriodicBit]                 = periodic_q;
    ctrl_word[CtrlPendingBit]                  = pending_q;
    ctrl_word[CtrlPrescaleMsb:CtrlPrescaleLsb] = prescale_q;
    counter_word                               = '0;
    counter_word[CounterWidth-1:0]             = counter_q;
    compare_word                               = '0;
    compare_word[CounterWidth-1:0]             = compare_q;

    csr_out = '0;
    if (sel_ctrl)         csr_out = ctrl_word;
    else if (sel_counter) csr_out = counter_word;
    else if (sel_compare) csr_out = compare_word;
  end

  // csr_out already carries the old value of whichever register is addressed.
  csr_rmw u_rmw (
    .old_value_i (csr_out),
    .csr_op_i    (csr_op),
    .rs1_zimm_i  (rs1_zimm),
    .rs1_data_i  (rs1_data),
    .new_value_o (wdata),
    .write_o     (rmw_we)
  );

  assign wr_ctrl    = sel_ctrl && rmw_we;
  assign wr_counter = sel_counter && rmw_we;
  assign wr_compare = sel_compare && rmw_we;

  assign tick  = en_q && (pre_q == prescale_q);
  assign match = tick && (counter_q == compare_q);

  always_comb begin
    pre_d      = pre_q;
    counter_d  = counter_q;
    compare_d  = compare_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    pending_d  = pending_q | match;
    prescale_d = prescale_q;
    irq_d      = match;

    if (en_q) pre_d = tick ? '0 : pre_q + 8'd1;

    if (tick) begin
      if (!match)          counter_d = counter_q + CounterWidth'(1);
      else if (periodic_q) counter_d = '0;
    end
    if (match && !periodic_q) en_d = 1'b0;

    // Software writes override the timer, except a match-set pending survives a clear.
    if (wr_ctrl) begin
      en_d       = wdata[CtrlEnBit];
      periodic_d = wdata[CtrlPeriodicBit];
      pending_d  = wdata[CtrlPendingBit] | match;
      prescale_d = wdata[CtrlPrescaleMsb:CtrlPrescaleLsb];
      if (!en_q && wdata[CtrlEnBit]) pre_d = '0;
    end
    if (wr_counter) counter_d = wdata[CounterWidth-1:0];
    if (wr_compare) compare_d = wdata[CounterWidth-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      pre_q      <= '0;
      counter_q  <= '0;
      compare_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      counter_q  <= counter_d;
      compare_q  <= compare_d;
      irq_q      <= irq_d;
    end
  end

  assign interrupt_out = irq_q;

endmodule

// File: tb/tb_csr_timer.sv
// tb/tb_csr_timer.sv - self-checking bench for csr_timer
module tb_csr_timer;
  import csr_timer_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    csr_enable = 1'b0;
  logic    csr_enable8 = 1'b0;
  CsrAddrT csr_addr = '0;
  r        rs1_zimm = '0;
  word     rs1_data = '0;
  csr_op_t csr_op = CSR_RS;
  word     csr_out, csr_out8;
  logic    interrupt_out, interrupt_out8;

  always #5 clk = ~clk;

  csr_timer dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_op(csr_op),
    .csr_out(csr_out), .interrupt_out(interrupt_out)
  );

  csr_timer #(.CounterWidth(8)) dut8 (
    .clk(clk), .reset(reset), .csr_enable(csr_enable8), .csr_addr(csr_addr),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_op(csr_op),
    .csr_out(csr_out8), .interrupt_out(interrupt_out8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the 32-bit timer, kept as plain fields.
  bit          m_en, m_per, m_pend, m_irq;
  int unsigned m_ps, m_pre;
  logic [31:0] m_cnt, m_cmp;

  bit  target8 = 1'b0;
  bit  rst_val = 1'b1;
  word obs_read, exp_read;
  bit  obs_irq, exp_irq;

  function automatic word model_read(bit ena, CsrAddrT a);
    if (!ena) return 32'd0;
    case (a)
      12'h400: return {16'h0, 8'(m_ps), 5'h0, m_pend, m_per, m_en};
      12'h401: return m_cnt;
      12'h402: return m_cmp;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_en = 0; m_per = 0; m_pend = 0; m_irq = 0;
    m_ps = 0; m_pre = 0; m_cnt = 0; m_cmp = 0;
  endfunction

  function automatic void model_clock(bit ena, CsrAddrT a, r z, word d, csr_op_t op);
    bit tick, hit, wr, n_en, n_per, n_pend;
    word src, old, nv;
    int unsigned n_ps, n_pre;
    logic [31:0] n_cnt, n_cmp;
    tick = m_en && (m_pre == m_ps);
    hit  = tick && (m_cnt == m_cmp);
    src  = (op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'd0, z} : d;
    old  = model_read(ena, a);
    wr   = ena && (a inside {12'h400, 12'h401, 12'h402});
    case (op)
      CSR_RW, CSR_RWI: nv = src;
      CSR_RS, CSR_RSI: begin nv = old | src;  if (z == 0) wr = 0; end
      CSR_RC, CSR_RCI: begin nv = old & ~src; if (z == 0) wr = 0; end
      default:         begin nv = old; wr = 0; end
    endcase
    n_pre = m_pre;
    if (m_en) n_pre = tick ? 0 : (m_pre + 1) % 256;
    n_cnt = m_cnt;
    if (tick) n_cnt = hit ? (m_per ? 32'd0 : m_cnt) : m_cnt + 32'd1;
    n_en   = m_en && !(hit && !m_per);
    n_per  = m_per;
    n_pend = m_pend || hit;
    n_ps   = m_ps;
    n_cmp  = m_cmp;
    if (wr && a == 12'h400) begin
      n_en = nv[0]; n_per = nv[1]; n_pend = nv[2] || hit; n_ps = nv[15:8];
      if (!m_en && nv[0]) n_pre = 0;
    end
    if (wr && a == 12'h401) n_cnt = nv;
    if (wr && a == 12'h402) n_cmp = nv;
    m_en = n_en; m_per = n_per; m_pend = n_pend; m_ps = n_ps; m_pre = n_pre;
    m_cnt = n_cnt; m_cmp = n_cmp; m_irq = hit;
  endfunction

  task automatic do_cycle(input bit ena, input CsrAddrT a, input r z, input word d, input csr_op_t op);
    @(negedge clk);
    reset       = rst_val;
    csr_enable  = ena && !target8;
    csr_enable8 = ena && target8;
    csr_addr    = a;
    rs1_zimm    = z;
    rs1_data    = d;
    csr_op      = op;
    #1;
    if (rst_val) model_reset();
    exp_read = model_read(ena && !target8, a);
    exp_irq  = m_irq;
    obs_read = target8 ? csr_out8 : csr_out;
    obs_irq  = target8 ? interrupt_out8 : interrupt_out;
    @(posedge clk);
    if (rst_val) model_reset();
    else model_clock(ena && !target8, a, z, d, op);
  endtask

  task automatic idle();
    do_cycle(1'b0, 12'h000, 5'd0, 32'd0, CSR_RS);
  endtask

  task automatic rd(input CsrAddrT a);
    do_cycle(1'b1, a, 5'd0, 32'd0, CSR_RS);
  endtask

  task automatic wr(input CsrAddrT a, input word d);
    do_cycle(1'b1, a, 5'd1, d, CSR_RW);
  endtask

  task automatic do_reset();
    rst_val = 1'b1;
    idle();
    idle();
    rst_val = 1'b0;
  endtask

  task automatic check(input string name, input word got, input word exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic check_irq(input string name, input bit exp);
    check(name, {31'd0, obs_irq}, {31'd0, exp});
  endtask

  typedef struct {
    bit      ena;
    CsrAddrT a;
    r        z;
    word     d;
    csr_op_t op;
    word     exp_read;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b1, 12'h400, 5'd0, 32'h0,        CSR_RS,  32'h0};
    tbl[1]  = '{1'b1, 12'h402, 5'd1, 32'h5,        CSR_RW,  32'h0};
    tbl[2]  = '{1'b1, 12'h402, 5'd0, 32'h0,        CSR_RS,  32'h5};
    tbl[3]  = '{1'b1, 12'h402, 5'd2, 32'h0,        CSR_RSI, 32'h5};
    tbl[4]  = '{1'b1, 12'h402, 5'd1, 32'h0,        CSR_RCI, 32'h7};
    tbl[5]  = '{1'b1, 12'h123, 5'd1, 32'hFF,       CSR_RW,  32'h0};
    tbl[6]  = '{1'b1, 12'h402, 5'd0, 32'hFFFFFFFF, CSR_RS,  32'h6};
    tbl[7]  = '{1'b1, 12'h401, 5'd1, 32'h12345678, CSR_RW,  32'h0};
    tbl[8]  = '{1'b1, 12'h401, 5'd3, 32'h78,       CSR_RC,  32'h12345678};
    tbl[9]  = '{1'b1, 12'h401, 5'd0, 32'h0,        CSR_RS,  32'h12345600};
    tbl[10] = '{1'b1, 12'h400, 5'd1, 32'hFFFFFFF8, CSR_RW,  32'h0};
    tbl[11] = '{1'b1, 12'h400, 5'd0, 32'h0,        CSR_RS,  32'h0000FF00};
    tbl[12] = '{1'b1, 12'h400, 5'd6, 32'h0,        CSR_RWI, 32'h0000FF00};
    tbl[13] = '{1'b1, 12'h400, 5'd0, 32'h0,        CSR_RS,  32'h6};
    tbl[14] = '{1'b1, 12'h400, 5'd4, 32'h0,        CSR_RCI, 32'h6};
    tbl[15] = '{1'b1, 12'h400, 5'd0, 32'h0,        CSR_RS,  32'h2};
    tbl[16] = '{1'b0, 12'h400, 5'd0, 32'h0,        CSR_RS,  32'h0};
    tbl[17] = '{1'b1, 12'h400, 5'd1, 32'h0,        CSR_RW,  32'h2};
    tbl[18] = '{1'b1, 12'h3FF, 5'd0, 32'h0,        CSR_RS,  32'h0};

    // Reset state
    rst_val = 1'b1;
    rd(12'h400); check("reset ctrl", obs_read, 32'h0); check_irq("reset irq", 1'b0);
    rd(12'h401); check("reset counter", obs_read, 32'h0);
    rd(12'h402); check("reset compare", obs_read, 32'h0);
    rst_val = 1'b0;

    // Register access table
    for (int i = 0; i < 19; i++) begin
      do_cycle(tbl[i].ena, tbl[i].a, tbl[i].z, tbl[i].d, tbl[i].op);
      check($sformatf("table[%0d] read", i), obs_read, tbl[i].exp_read);
      check_irq($sformatf("table[%0d] irq", i), 1'b0);
    end

    // Reset mid-count, on the match cycle
    do_reset();
    wr(12'h402, 32'd3);
    wr(12'h400, 32'h3);
    for (int k = 0; k < 3; k++) begin
      rd(12'h401); check($sformatf("prereset counter k=%0d", k), obs_read, k);
    end
    rst_val = 1'b1;
    rd(12'h400); check("midreset ctrl", obs_read, 32'h0); check_irq("midreset irq", 1'b0);
    rd(12'h401); check("midreset counter", obs_read, 32'h0);
    rd(12'h402); check("midreset compare", obs_read, 32'h0);
    rst_val = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd(12'h400);
      check_irq($sformatf("postreset irq k=%0d", k), 1'b0);
      check($sformatf("postreset ctrl k=%0d", k), obs_read, 32'h0);
    end

    // Periodic, compare 3, prescale 0
    do_reset();
    wr(12'h402, 32'd3);
    wr(12'h400, 32'h3);
    for (int k = 0; k < 9; k++) begin
      rd(12'h401);
      check($sformatf("periodic counter k=%0d", k), obs_read, k % 4);
      check_irq($sformatf("periodic irq k=%0d", k), (k > 0) && (k % 4 == 0));
    end

    // One-shot, compare 2, prescale 4
    do_reset();
    wr(12'h402, 32'd2);
    wr(12'h400, 32'h0401);
    for (int k = 0; k < 20; k++) begin
      rd(12'h400);
      check($sformatf("oneshot ctrl k=%0d", k), obs_read, (k < 15) ? 32'h0401 : 32'h0404);
      check_irq($sformatf("oneshot irq k=%0d", k), k == 15);
    end
    rd(12'h401); check("oneshot counter hold", obs_read, 32'd2);

    // Pending clear racing a match, and no-write set/clear from x0
    do_reset();
    wr(12'h402, 32'd3);
    wr(12'h400, 32'h3);
    for (int k = 0; k < 3; k++) begin
      rd(12'h400); check($sformatf("pend ctrl k=%0d", k), obs_read, 32'h3);
    end
    do_cycle(1'b1, 12'h400, 5'd4, 32'h0, CSR_RCI); check("pend rci on match", obs_read, 32'h3);
    rd(12'h400); check("pend survives clear", obs_read, 32'h7); check_irq("pend irq", 1'b1);
    do_cycle(1'b1, 12'h400, 5'd4, 32'h0, CSR_RCI); check("pend rci idle", obs_read, 32'h7);
    rd(12'h400); check("pend cleared", obs_read, 32'h3);
    do_cycle(1'b1, 12'h400, 5'd0, 32'hFFFFFFFF, CSR_RC); check("rc x0 read", obs_read, 32'h3);
    rd(12'h400); check("rc x0 no write", obs_read, 32'h7); check_irq("rc x0 irq", 1'b1);

    // Counter write on a tick cycle, prescale 3
    do_reset();
    wr(12'h402, 32'd100);
    wr(12'h400, 32'h0303);
    for (int k = 0; k < 7; k++) begin
      rd(12'h401); check($sformatf("coll counter k=%0d", k), obs_read, k / 4);
    end
    wr(12'h401, 32'd10); check("coll write read", obs_read, 32'd1);
    for (int k = 8; k < 12; k++) begin
      rd(12'h401); check($sformatf("coll counter k=%0d", k), obs_read, 32'd10);
    end
    rd(12'h401); check("coll phase kept", obs_read, 32'd11);

    // CounterWidth = 8 wrap at compare 255
    do_reset();
    target8 = 1'b1;
    wr(12'h402, 32'hFFFFFFFF);
    rd(12'h402); check("w8 compare", obs_read, 32'hFF);
    wr(12'h401, 32'd254);
    wr(12'h400, 32'h3);
    rd(12'h401); check("w8 k0", obs_read, 32'd254); check_irq("w8 irq k0", 1'b0);
    rd(12'h401); check("w8 k1", obs_read, 32'd255); check_irq("w8 irq k1", 1'b0);
    rd(12'h401); check("w8 k2", obs_read, 32'd0);   check_irq("w8 irq k2", 1'b1);
    rd(12'h401); check("w8 k3", obs_read, 32'd1);   check_irq("w8 irq k3", 1'b0);
    target8 = 1'b0;

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit      ena;
      CsrAddrT a;
      r        z;
      word     d;
      csr_op_t op;
      ena = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 4))
        0: a = 12'h400;
        1: a = 12'h401;
        2: a = 12'h402;
        3: a = 12'h3FF;
        default: a = 12'h403;
      endcase
      case ($urandom_range(0, 5))
        0: op = CSR_RW;
        1: op = CSR_RS;
        2: op = CSR_RC;
        3: op = CSR_RWI;
        4: op = CSR_RSI;
        default: op = CSR_RCI;
      endcase
      z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case (a)
        12'h400: d = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom & 32'h0307) | 32'h1);
        12'h401: d = $urandom_range(0, 8);
        12'h402: d = $urandom_range(0, 6);
        default: d = $urandom;
      endcase
      do_cycle(ena, a, z, d, op);
      check("rand read", obs_read, exp_read);
      check_irq("rand irq", exp_irq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
